// File: rtl/rc4_ksa_engine.sv
// RC4 key-scheduling engine: optional identity fill of the S-box RAM, then the
// KSA swap loop over a 2^ADDR_W-entry single-port synchronous RAM.
module rc4_ksa_engine #(
  parameter int ADDR_W    = 8,
  parameter int KEY_BYTES = 3
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic                   start,
  input  logic                   init_en,
  input  logic [8*KEY_BYTES-1:0] secret_key,
  output logic                   busy,
  output logic                   done,
  output logic [ADDR_W-1:0]      address,
  output logic [7:0]             data,
  output logic                   wren,
  input  logic [7:0]             q
);

  localparam int KW = (KEY_BYTES > 1) ? $clog2(KEY_BYTES) : 1;
  localparam logic [ADDR_W-1:0] I_LAST = {ADDR_W{1'b1}};
  localparam logic [KW-1:0]     K_LAST = KW'(KEY_BYTES - 1);

  typedef enum logic [3:0] {
    S_IDLE, S_FILL, S_READ_I, S_LATCH_I, S_CALC_J,
    S_READ_J, S_LATCH_J, S_WRITE_I, S_WRITE_J, S_DONE
  } state_e;

  state_e                 state_q, state_d;
  logic [ADDR_W-1:0]      i_q, i_d, j_q, j_d;
  logic [KW-1:0]          k_q, k_d;
  logic [7:0]             si_q, si_d, sj_q, sj_d;
  logic [8*KEY_BYTES-1:0] key_q, key_d;
  logic                   init_q, init_d;
  logic [7:0]             key_byte;

  // key[0] is the most significant byte of the latched key
  always_comb begin
    key_byte = '0;
    for (int b = 0; b < KEY_BYTES; b++)
      if (k_q == KW'(b)) key_byte = key_q[8*(KEY_BYTES-1-b) +: 8];
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      i_q     <= '0;
      j_q     <= '0;
      k_q     <= '0;
      si_q    <= '0;
      sj_q    <= '0;
      key_q   <= '0;
      init_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      i_q     <= i_d;
      j_q     <= j_d;
      k_q     <= k_d;
      si_q    <= si_d;
      sj_q    <= sj_d;
      key_q   <= key_d;
      init_q  <= init_d;
    end
  end

  always_comb begin
    state_d = state_q;
    i_d     = i_q;
    j_d     = j_q;
    k_d     = k_q;
    si_d    = si_q;
    sj_d    = sj_q;
    key_d   = key_q;
    init_d  = init_q;
    address = '0;
    data    = '0;
    wren    = 1'b0;
    done    = 1'b0;
    busy    = (state_q != S_IDLE);
    unique case (state_q)
      S_IDLE: if (start) begin
        key_d   = secret_key;
        init_d  = init_en;
        i_d     = '0;
        j_d     = '0;
        k_d     = '0;
        state_d = init_en ? S_FILL : S_READ_I;
      end
      S_FILL: begin
        wren    = init_q;
        address = i_q;
        data    = 8'(i_q);
        if (i_q == I_LAST) begin
          i_d     = '0;
          state_d = S_READ_I;
        end else begin
          i_d = i_q + ADDR_W'(1);
        end
      end
      S_READ_I: begin
        address = i_q;
        state_d = S_LATCH_I;
      end
      S_LATCH_I: begin
        address = i_q;
        si_d    = q;
        state_d = S_CALC_J;
      end
      S_CALC_J: begin
        // 8-bit wrap then truncation equals arithmetic mod 2^ADDR_W
        j_d     = ADDR_W'(8'(j_q) + si_q + key_byte);
        state_d = S_READ_J;
      end
      S_READ_J: begin
        address = j_q;
        state_d = S_LATCH_J;
      end
      S_LATCH_J: begin
        address = j_q;
        sj_d    = q;
        state_d = S_WRITE_I;
      end
      S_WRITE_I: begin
        wren    = 1'b1;
        address = i_q;
        data    = sj_q;
        state_d = S_WRITE_J;
      end
      S_WRITE_J: begin
        wren    = 1'b1;
        address = j_q;
        data    = si_q;
        if (i_q == I_LAST) begin
          state_d = S_DONE;
        end else begin
          i_d     = i_q + ADDR_W'(1);
          k_d     = (k_q == K_LAST) ? '0 : k_q + KW'(1);
          state_d = S_READ_I;
        end
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_rc4_ksa_engine.sv
// Bench for rc4_ksa_engine: default config plus a 16-entry/5-byte-key instance,
// each with a behavioural sync RAM, checked against a software KSA model.
module tb_rc4_ksa_engine;
  logic        clock = 1'b0, reset_n = 1'b0;
  logic        start = 1'b0, init_en = 1'b0;
  logic [23:0] secret_key = '0;
  logic        busy, done, wren;
  logic [7:0]  address, data, q;
  logic        start4 = 1'b0, init4 = 1'b0;
  logic [39:0] key4 = '0;
  logic        busy4, done4, wren4;
  logic [3:0]  address4;
  logic [7:0]  data4, q4;

  int checks = 0, errors = 0, cyc = 0;
  logic [7:0]  mem[256], pre[256], mem4[16];
  logic        ld = 1'b0;
  logic [15:0] wlog[$], wlog4[$];
  int done_cnt = 0, done_at = 0, done_cnt4 = 0, done_at4 = 0;
  int ref_s[256], ref_key[32];
  logic [15:0] ref_tr[$];

  rc4_ksa_engine u_dut (
    .clock(clock), .reset_n(reset_n), .start(start), .init_en(init_en),
    .secret_key(secret_key), .busy(busy), .done(done), .address(address),
    .data(data), .wren(wren), .q(q));

  rc4_ksa_engine #(.ADDR_W(4), .KEY_BYTES(5)) u_dut4 (
    .clock(clock), .reset_n(reset_n), .start(start4), .init_en(init4),
    .secret_key(key4), .busy(busy4), .done(done4), .address(address4),
    .data(data4), .wren(wren4), .q(q4));

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  always @(posedge clock) begin
    if (ld) begin
      for (int n = 0; n < 256; n++) mem[n] <= pre[n];
    end else if (wren) mem[address] <= data;
    q <= mem[address];
  end

  always @(posedge clock) begin
    if (wren4) mem4[address4] <= data4;
    q4 <= mem4[address4];
  end

  always @(negedge clock) begin
    if (wren) wlog.push_back({address, data});
    if (done) begin done_cnt <= done_cnt + 1; done_at <= cyc; end
    if (wren4) wlog4.push_back({4'b0, address4, data4});
    if (done4) begin done_cnt4 <= done_cnt4 + 1; done_at4 <= cyc; end
  end

  // Software KSA on ref_s; records the two writes of each iteration
  task automatic ref_ksa(input int n, input int kb);
    int j, t;
    j = 0;
    ref_tr.delete();
    for (int i = 0; i < n; i++) begin
      j = (j + ref_s[i] + ref_key[i % kb]) % n;
      t = ref_s[i];
      ref_s[i] = ref_s[j];
      ref_s[j] = t;
      ref_tr.push_back({8'(i), 8'(ref_s[i])});
      ref_tr.push_back({8'(j), 8'(t)});
    end
  endtask

  task automatic ref_identity(input int n);
    for (int x = 0; x < n; x++) ref_s[x] = x;
  endtask

  task automatic ref_key24(input logic [23:0] k);
    for (int b = 0; b < 3; b++) ref_key[b] = int'(k[23-8*b -: 8]);
  endtask

  function automatic int trace_diff(input bit four, input int off);
    for (int x = 0; x < ref_tr.size(); x++) begin
      logic [15:0] a;
      a = four ? wlog4[off+x] : wlog[off+x];
      if (a !== ref_tr[x]) return x;
    end
    return -1;
  endfunction

  function automatic int ram_diff(input bit four, input int n);
    for (int x = 0; x < n; x++) begin
      logic [7:0] v;
      v = four ? mem4[x] : mem[x];
      if (v !== 8'(ref_s[x])) return x;
    end
    return -1;
  endfunction

  task automatic start_run(input logic init, input logic [23:0] key, output int e0);
    @(negedge clock);
    init_en = init; secret_key = key; start = 1'b1;
    wlog.delete();
    @(posedge clock); #1;
    e0 = cyc; start = 1'b0;
    init_en = ~init; secret_key = 24'($urandom);
  endtask

  task automatic wait_done(input int base, input int budget, output bit ok);
    int t;
    t = 0;
    while (done_cnt == base && t < budget) begin @(posedge clock); t++; end
    ok = (done_cnt != base);
  endtask

  task automatic test_reset();
    #3;
    checks++;
    if ({busy, done, wren, address, data} !== 19'h0) begin
      errors++; $display("FAIL reset_outputs: got %h expected 0", {busy, done, wren, address, data});
    end
    checks++;
    if ({busy4, done4, wren4, address4, data4} !== 15'h0) begin
      errors++; $display("FAIL reset_outputs4: got %h expected 0", {busy4, done4, wren4, address4, data4});
    end
    @(negedge clock); reset_n = 1'b1;
    repeat (2) @(negedge clock);
    checks++;
    if ({busy, done, wren, address, data} !== 19'h0) begin
      errors++; $display("FAIL idle_outputs: got %h expected 0", {busy, done, wren, address, data});
    end
  endtask

  // Full run with fill; checks timing, single done pulse, write trace and RAM
  task automatic run_full_check(input string nm, input logic [23:0] key);
    int e0, base, d; bit ok;
    base = done_cnt;
    start_run(1'b1, key, e0);
    wait_done(base, 3000, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL %s_timeout: no done within budget", nm); end
    checks++;
    if (done_at - e0 !== 2048) begin
      errors++; $display("FAIL %s_done_time: got %0d expected 2048", nm, done_at - e0);
    end
    repeat (4) @(posedge clock);
    checks++;
    if (done_cnt - base !== 1 || busy !== 1'b0) begin
      errors++; $display("FAIL %s_done_pulse: got %0d pulses busy=%b expected 1 busy=0", nm, done_cnt - base, busy);
    end
    ref_identity(256); ref_key24(key); ref_ksa(256, 3);
    checks++;
    d = trace_diff(1'b0, 256);
    if (wlog.size() !== 768 || d !== -1) begin
      errors++; $display("FAIL %s_trace: got size %0d first diff %0d expected 768/-1", nm, wlog.size(), d);
    end
    checks++;
    d = ram_diff(1'b0, 256);
    if (d !== -1) begin
      errors++; $display("FAIL %s_ram: got mem[%0d]=%h expected %h", nm, d, mem[d], ref_s[d]);
    end
  endtask

  task automatic test_fill_zero_key();
    int bad;
    run_full_check("zero_key", 24'h000000);
    bad = 0;
    for (int n = 0; n < 256; n++) if (wlog[n] !== {8'(n), 8'(n)}) bad++;
    checks++;
    if (bad != 0) begin errors++; $display("FAIL fill_pattern: got %0d bad entries expected 0", bad); end
    checks++;
    if (wlog[260] !== 16'h0203 || wlog[261] !== 16'h0302) begin
      errors++; $display("FAIL iter2_writes: got %h %h expected 0203 0302", wlog[260], wlog[261]);
    end
  endtask

  task automatic test_byte_order();
    run_full_check("key010000", 24'h010000);
    checks++;
    if (wlog[256] !== 16'h0001 || wlog[257] !== 16'h0100) begin
      errors++; $display("FAIL byte_order: got %h %h expected 0001 0100", wlog[256], wlog[257]);
    end
    run_full_check("key000001", 24'h000001);
    checks++;
    if (wlog[256] !== 16'h0000 || wlog[257] !== 16'h0000) begin
      errors++; $display("FAIL byte_order_ctrl: got %h %h expected 0000 0000", wlog[256], wlog[257]);
    end
  endtask

  task automatic test_random_keys();
    for (int r = 0; r < 3; r++) run_full_check("rand_key", 24'($urandom));
  endtask

  // No fill on a preloaded permutation, with start pulses while busy
  task automatic test_no_init_pulses();
    int e0, base, d, t, x; bit ok;
    logic [7:0] tmp; logic [23:0] key;
    for (int n = 0; n < 256; n++) pre[n] = 8'(n);
    for (int n = 255; n > 0; n--) begin
      x = int'($urandom_range(n, 0));
      tmp = pre[n]; pre[n] = pre[x]; pre[x] = tmp;
    end
    for (int n = 0; n < 256; n++) ref_s[n] = int'(pre[n]);
    @(negedge clock); ld = 1'b1;
    @(negedge clock); ld = 1'b0;
    key = 24'($urandom);
    base = done_cnt;
    start_run(1'b0, key, e0);
    for (int p = 0; p < 4; p++) begin
      repeat (300) @(negedge clock);
      start = 1'b1; init_en = 1'b1;
      @(negedge clock);
      start = 1'b0;
    end
    wait_done(base, 2000, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL noinit_timeout: no done within budget"); end
    checks++;
    if (done_at - e0 !== 1792) begin
      errors++; $display("FAIL noinit_done_time: got %0d expected 1792", done_at - e0);
    end
    repeat (4) @(posedge clock);
    checks++;
    if (done_cnt - base !== 1 || busy !== 1'b0) begin
      errors++; $display("FAIL busy_start_ignored: got %0d pulses busy=%b expected 1 busy=0", done_cnt - base, busy);
    end
    ref_key24(key); ref_ksa(256, 3);
    t = trace_diff(1'b0, 0);
    d = ram_diff(1'b0, 256);
    checks++;
    if (wlog.size() !== 512 || t !== -1 || d !== -1) begin
      errors++; $display("FAIL noinit_result: got size %0d trace diff %0d ram diff %0d expected 512/-1/-1", wlog.size(), t, d);
    end
  endtask

  task automatic test_start_held();
    int e0, e0b, base, d; bit ok; logic [23:0] key;
    key = 24'($urandom);
    base = done_cnt;
    @(negedge clock);
    init_en = 1'b1; secret_key = key; start = 1'b1;
    @(posedge clock); #1; e0 = cyc;
    wait_done(base, 3000, ok);
    checks++;
    if (!ok || done_at - e0 !== 2048) begin
      errors++; $display("FAIL held_first_done: got ok=%b time %0d expected 1/2048", ok, done_at - e0);
    end
    while (cyc < e0 + 2049) @(negedge clock);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++; $display("FAIL held_idle_gap: got busy=%b done=%b expected 0 0", busy, done);
    end
    wlog.delete();
    @(posedge clock); #1;
    e0b = cyc; start = 1'b0; secret_key = 24'($urandom);
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL held_restart: got busy=%b expected 1", busy); end
    wait_done(base + 1, 3000, ok);
    checks++;
    if (!ok || done_at - e0b !== 2048) begin
      errors++; $display("FAIL held_second_done: got ok=%b time %0d expected 1/2048", ok, done_at - e0b);
    end
    ref_identity(256); ref_key24(key); ref_ksa(256, 3);
    d = ram_diff(1'b0, 256);
    checks++;
    if (d !== -1 || trace_diff(1'b0, 256) !== -1) begin
      errors++; $display("FAIL held_second_result: got ram diff %0d expected -1", d);
    end
  endtask

  task automatic test_generalised();
    int e0, base, t, d;
    base = done_cnt4;
    @(negedge clock);
    init4 = 1'b1; key4 = 40'h0102030405; start4 = 1'b1;
    wlog4.delete();
    @(posedge clock); #1;
    e0 = cyc; start4 = 1'b0; key4 = 40'hffffffffff;
    t = 0;
    while (done_cnt4 == base && t < 500) begin @(posedge clock); t++; end
    checks++;
    if (done_cnt4 == base || done_at4 - e0 !== 128) begin
      errors++; $display("FAIL gen_done_time: got cnt %0d time %0d expected 128", done_cnt4 - base, done_at4 - e0);
    end
    ref_identity(16);
    for (int b = 0; b < 5; b++) ref_key[b] = b + 1;
    ref_ksa(16, 5);
    checks++;
    if (wlog4[26] !== ref_tr[10] || wlog4[27] !== ref_tr[11]) begin
      errors++; $display("FAIL gen_iter5_key0: got %h %h expected %h %h", wlog4[26], wlog4[27], ref_tr[10], ref_tr[11]);
    end
    t = trace_diff(1'b1, 16);
    d = ram_diff(1'b1, 16);
    checks++;
    if (wlog4.size() !== 48 || t !== -1 || d !== -1) begin
      errors++; $display("FAIL gen_result: got size %0d trace diff %0d ram diff %0d expected 48/-1/-1", wlog4.size(), t, d);
    end
  endtask

  task automatic test_reset_mid();
    int e0;
    start_run(1'b1, 24'($urandom), e0);
    while (cyc < e0 + 1000) @(negedge clock);
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL mid_busy: got %b expected 1", busy); end
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if ({busy, done, wren, address, data} !== 19'h0) begin
      errors++; $display("FAIL async_reset: got %h expected 0", {busy, done, wren, address, data});
    end
    @(negedge clock); reset_n = 1'b1;
    @(negedge clock);
    run_full_check("after_reset", 24'($urandom));
  endtask

  initial begin
    test_reset();
    test_fill_zero_key();
    test_byte_order();
    test_random_keys();
    test_no_init_pulses();
    test_start_held();
    test_generalised();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
